sub_64_seq: RTL and testbench



---
 rtl/sub_64_seq_if.sv | 38 +++
 rtl/sub_64_seq.sv | 149 ++++++++++++++
 tb/tb_sub_64_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_64_seq_if.sv
// sub_64_seq_if: request/result bundle between a datapath controller (master)
// and the sequential subtractor (slave). The ovf signal exists only when the
// SUB_OVF_EN macro is defined.
interface sub_64_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  ready, valid, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, valid, diff, b_out, ovf
    );
`else
    modport master (
        output start, a, b, b_in,
        input  ready, valid, diff, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, valid, diff, b_out
    );
`endif
endinterface

// File: rtl/sub_64_seq.sv
// sub_64_seq: multi-cycle subtractor computing a - b - b_in, one SLICE-bit
// slice per clock with the borrow registered between slices. WIDTH must be a
// multiple of SLICE. Optional signed-overflow output enabled by the macro
// SUB_OVF_EN; the default build omits the ovf port and all overflow logic.
module sub_64_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_64_seq_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    // Operand snapshot and partial result being assembled slice by slice.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_next;

    // Architecturally visible result registers.
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             valid_q;

    logic [KW-1:0]    k_q;
    logic             borrow_q;

    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE:0]   slice_sum;
    int               slice_lo;

    logic             accept;
    logic             last;
    logic             done;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (k_q == K_LAST);
    assign done   = (state == CALC) && last;

    // Single-slice arithmetic: a_k - b_k - borrow as a_k + ~b_k + ~borrow.
    // NOTE: every variable driven here gets a value before any conditional
    // code, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slice_lo  = SLICE * int'(k_q);
        a_k       = a_q[slice_lo +: SLICE];
        b_k       = b_q[slice_lo +: SLICE];
        slice_sum = {1'b0, a_k} + {1'b0, ~b_k} + {{SLICE{1'b0}}, ~borrow_q};
        part_next = part_q;
        part_next[slice_lo +: SLICE] = slice_sum[SLICE-1:0];
    end

    // FSM next-state: leave IDLE on start, return after the last slice.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture and partial-result assembly.
    // NOTE: these registers carry no reset: operands are loaded at acceptance
    // and every partial slice is written before diff copies it, so their
    // power-up contents are never observable.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
        if (state == CALC) begin
            part_q <= part_next;
        end
    end

    // Slice counter and inter-slice borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            k_q      <= '0;
            borrow_q <= bus.b_in;
        end else if (state == CALC) begin
            k_q      <= k_q + 1'b1;
            borrow_q <= ~slice_sum[SLICE];
        end
    end

    // Result registers: updated only on the edge that finishes the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q  <= '0;
            b_out_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= done;
            if (done) begin
                diff_q  <= part_next;
                b_out_q <= ~slice_sum[SLICE];
            end
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: operand signs differ and the result sign differs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (done) begin
            ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ part_next[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.ready = (state == IDLE);
    assign bus.valid = valid_q;
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;

endmodule

// File: tb/tb_sub_64_seq.sv
// tb_sub_64_seq: scoreboard bench for sub_64_seq. Expected results are pushed
// at acceptance and popped when valid pulses. Overflow checks are compiled in
// when SUB_OVF_EN is defined.
`timescale 1ns/1ps
module tb_sub_64_seq;

    localparam int W  = 64;
    localparam int NS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sub_64_seq_if #(.WIDTH(W)) bus ();

    sub_64_seq #(.WIDTH(W), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         b_out;
        logic         ovf;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic         chk;
        logic [W-1:0] diff;
        logic         b_out;
    } vec_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] hold_diff  = '0;
    logic         hold_b_out = 1'b0;
    logic         hold_ovf   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: 65-bit unsigned subtraction; bit W is the borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input int acc);
        exp_t       e;
        logic [W:0] full;
        full    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.diff  = full[W-1:0];
        e.b_out = full[W];
        e.ovf   = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        e.acc   = acc;
        return e;
    endfunction

    // Monitor: scores each valid pulse, checks outputs hold between results,
    // and logs accepted requests into the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
            hold_diff  = '0;
            hold_b_out = 1'b0;
            hold_ovf   = 1'b0;
        end else begin
            if (bus.valid === 1'b1) begin
                tests++;
                if (prev_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL valid_pulse: valid high two cycles in a row at cycle %0d, required single pulse", cyc);
                end
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: valid at cycle %0d with no outstanding request", cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.diff !== e.diff || bus.b_out !== e.b_out || (cyc - e.acc) !== NS) begin
                        fails++;
                        $display("FAIL result: diff=%h b_out=%b latency=%0d, required diff=%h b_out=%b latency=%0d",
                                 bus.diff, bus.b_out, cyc - e.acc, e.diff, e.b_out, NS);
                    end
`ifdef SUB_OVF_EN
                    tests++;
                    if (bus.ovf !== e.ovf) begin
                        fails++;
                        $display("FAIL ovf: got %b, required %b (diff=%h)", bus.ovf, e.ovf, e.diff);
                    end
                    hold_ovf = e.ovf;
`endif
                    hold_diff  = e.diff;
                    hold_b_out = e.b_out;
                end
            end else begin
                tests++;
                if (bus.diff !== hold_diff || bus.b_out !== hold_b_out) begin
                    fails++;
                    $display("FAIL hold: diff=%h b_out=%b changed without valid, required diff=%h b_out=%b",
                             bus.diff, bus.b_out, hold_diff, hold_b_out);
                end
`ifdef SUB_OVF_EN
                tests++;
                if (bus.ovf !== hold_ovf) begin
                    fails++;
                    $display("FAIL ovf_hold: got %b, required %b", bus.ovf, hold_ovf);
                end
`endif
            end
            prev_valid = bus.valid;
            if (bus.start === 1'b1 && bus.ready === 1'b1)
                sb.push_back(model(bus.a, bus.b, bus.b_in, cyc + 1));
        end
    end

    // Present one request for a single cycle; returns at the next negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.a     = a;
        bus.b     = b;
        bus.b_in  = bin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait until the scoreboard drains and the block is idle, bounded.
    task automatic wait_done(output bit ok);
        int n = 0;
        while ((sb.size() != 0 || bus.ready !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.diff !== '0 || bus.b_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: ready=%b valid=%b diff=%h b_out=%b, required 1 0 0 0",
                     bus.ready, bus.valid, bus.diff, bus.b_out);
        end
`ifdef SUB_OVF_EN
        tests++;
        if (bus.ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: got %b, required 0", bus.ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(64'd645, 64'd123, 1'b1);
        for (int i = 1; i <= NS; i++) begin
            tests++;
            if (bus.ready !== 1'b0 || bus.valid !== 1'b0) begin
                fails++;
                $display("FAIL busy_cycle%0d: ready=%b valid=%b, required 0 0", i, bus.ready, bus.valid);
            end
            @(negedge clk);
        end
        tests++;
        if (bus.valid !== 1'b1 || bus.ready !== 1'b1 || bus.diff !== 64'd521 || bus.b_out !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: valid=%b ready=%b diff=%0d b_out=%b, required 1 1 521 0",
                     bus.valid, bus.ready, bus.diff, bus.b_out);
        end
        @(negedge clk);
        tests++;
        if (bus.valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: valid=%b one cycle after result, required 0", bus.valid);
        end
    endtask

    task automatic test_patterns();
        vec_t vecs[$];
        bit   ok;
        vecs.push_back('{64'd10, 64'd20, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1});
        vecs.push_back('{64'h0001_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'd0, 1'b0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{{$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0, '0, 1'b0});
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL pattern%0d_timeout: %0d results outstanding, required 0", i, sb.size());
                sb.delete();
            end
            if (vecs[i].chk) begin
                tests++;
                if (bus.diff !== vecs[i].diff || bus.b_out !== vecs[i].b_out) begin
                    fails++;
                    $display("FAIL pattern%0d: diff=%h b_out=%b, required diff=%h b_out=%b",
                             i, bus.diff, bus.b_out, vecs[i].diff, vecs[i].b_out);
                end
            end
`ifdef SUB_OVF_EN
            if (i == 5 || i == 6) begin
                tests++;
                if (bus.ovf !== (i == 5)) begin
                    fails++;
                    $display("FAIL pattern%0d_ovf: got %b, required %b", i, bus.ovf, (i == 5));
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        // Held start: the second request is taken in the first valid cycle.
        bus.a     = 64'd855594;
        bus.b     = 64'd4215;
        bus.b_in  = 1'b1;
        bus.start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            @(negedge clk);
            while (bus.valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (r == 1) bus.start = 1'b0;
            tests++;
            if (bus.valid !== 1'b1 || bus.diff !== 64'd851378 || bus.ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_result%0d: valid=%b diff=%0d ready=%b, required 1 851378 1",
                         r, bus.valid, bus.diff, bus.ready);
            end
            if (r == 0) begin
                @(negedge clk);
                tests++;
                if (bus.ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_accept: ready=%b after valid cycle with start held, required 0", bus.ready);
                end
            end
        end
        wait_done(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        // Busy: start stays high and a changes mid-operation; both are ignored.
        bus.a     = 64'd855594;
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.a = 64'd0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok);
        tests++;
        if (!ok || bus.diff !== 64'd851378) begin
            fails++;
            $display("FAIL busy_ignore: diff=%0d done=%b, required 851378 1", bus.diff, ok);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        issue(64'd777, 64'd7, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        tests++;
        if (bus.valid !== 1'b0 || bus.ready !== 1'b1 || bus.diff !== '0 || bus.b_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b ready=%b diff=%h b_out=%b, required 0 1 0 0",
                     bus.valid, bus.ready, bus.diff, bus.b_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (bus.valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_novalid: valid=%b %0d cycles after release, required 0", bus.valid, i);
            end
        end
        issue(64'd1000, 64'd1, 1'b0);
        wait_done(ok);
        tests++;
        if (!ok || bus.diff !== 64'd999 || bus.b_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_recover: diff=%0d b_out=%b done=%b, required 999 0 1", bus.diff, bus.b_out, ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
